uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 16, clk cycles per serial bit period (even, ≥4).
REQ-002 SHALL have port: clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: rx_in  input  1  asynchronous serial line, idle high, 8N1, LSB first (same frame the PISO-based transmitter produces).
REQ-005 SHALL have port: data_out  output  8  last correctly framed received byte.
REQ-006 SHALL have port: data_valid  output  1  one-cycle pulse, data_out updated with new byte.
REQ-007 SHALL have port: frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-008 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port: bit_count  output  4  data bits captured in current frame (0-8).

Function
REQ-010 SHALL pass rx_in through a 2-flop synchronizer; rx_s (second flop) is the only line value used by the FSM.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, BREAK, with a clock counter cnt (width ≥ clog2(CLKS_PER_BIT)).
REQ-012 IDLE: cnt=0, bit_count=0; rx_s==0 -> START; else stay.
REQ-013 START: cnt increments each cycle; at cnt==CLKS_PER_BIT/2-1, rx_s==0 -> DATA with cnt=0, rx_s==1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: cnt increments; at cnt==CLKS_PER_BIT-1, cnt=0, rx_s shifted into MSB of 8-bit shift register (right shift, so first bit ends in bit 0), bit_count+1; when bit_count reaches 8 -> STOP.
REQ-015 STOP: cnt increments; at cnt==CLKS_PER_BIT-1 sample rx_s: 1 -> data_out<=shift register, data_valid=1 for that one cycle, -> IDLE; 0 -> frame_err=1 for one cycle, data_out unchanged, -> BREAK.
REQ-016 BREAK: stay until rx_s==1, then -> IDLE; no start detection while in BREAK.
REQ-017 data_valid and frame_err SHALL never assert in the same cycle and SHALL be low in all other cycles.
REQ-018 data_out SHALL hold its value between valid frames.
REQ-019 Sampling points SHALL be mid-bit: START check at CLKS_PER_BIT/2 cycles after start edge seen on rx_s, each following sample CLKS_PER_BIT later.
REQ-020 Back-to-back frames: a falling edge on rx_s in the cycle after STOP->IDLE SHALL be accepted as a new start.
REQ-021 rx_in changes during DATA/STOP between sample points SHALL not affect captured data.

Reset
REQ-022 rst SHALL force state=IDLE, cnt=0, bit_count=0, shift register=0, data_out=0, data_valid=0, frame_err=0, busy=0, both synchronizer flops=1.
REQ-023 rst SHALL take priority over all other activity, including mid-frame; after release an in-progress frame SHALL be ignored until the line returns to IDLE detection (a low line after reset is treated as a new start).

Verification (CLKS_PER_BIT=16)
REQ-024 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> data_out=0xA5, data_valid one pulse ~154 cycles (2 sync + 8 + 9x16) after rx_in falls, frame_err=0.
REQ-025 rx_in low for 4 cycles then high -> START aborts to IDLE, no data_valid/frame_err, busy returns 0.
REQ-026 Frame 0x3C with stop bit 0, line held low 40 cycles -> frame_err one pulse, data_out keeps previous value, busy high until line high, then IDLE.
REQ-027 Back-to-back frames 0x00 then 0xFF, no idle gap -> two data_valid pulses 160 cycles apart, data_out 0x00 then 0xFF.
REQ-028 rst asserted mid-DATA (bit_count=4) -> next cycle all outputs at reset values; subsequent clean frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronised line, mid-bit sampling, framing-error detection
// and a BREAK state that waits for the line to return high before accepting a new start.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [3:0] bit_count
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bitCount_q;
  logic [7:0]       shiftReg_q;
  logic [7:0]       dataOut_q;
  logic             dataValid_q;
  logic             frameErr_q;
  logic             rxMeta_q;
  logic             rxSync_q;

  // Synchroniser resets to the idle-high line level so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx_in;
      rxSync_q <= rxMeta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitCount_q  <= '0;
      shiftReg_q  <= '0;
      dataOut_q   <= '0;
      dataValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      dataValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q      <= '0;
          bitCount_q <= '0;
          if (!rxSync_q) state_q <= START;
        end
        // Re-check the line half a bit in; a high line here means the edge was a glitch.
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            state_q <= rxSync_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q      <= '0;
            shiftReg_q <= {rxSync_q, shiftReg_q[7:1]};
            bitCount_q <= bitCount_q + 4'd1;
            if (bitCount_q == 4'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            if (rxSync_q) begin
              dataOut_q   <= shiftReg_q;
              dataValid_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              frameErr_q <= 1'b1;
              state_q    <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BREAK: begin
          cnt_q <= '0;
          if (rxSync_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out   = dataOut_q;
  assign data_valid = dataValid_q;
  assign frame_err  = frameErr_q;
  assign busy       = (state_q != IDLE);
  assign bit_count  = bitCount_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the driver queues the expected pulse (kind, byte, cycle)
// for each frame, and a monitor pops and compares whenever data_valid or frame_err fires.
module tb_uart_rx;

  localparam int CPB = 16;
  // Cycles from driving the start bit low to the result pulse: 2 sync + 1 + 8 + 9x16.
  localparam int LATENCY = 155;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
  logic [3:0] bit_count;

  typedef struct {
    logic       isErr;
    logic [7:0] data;
    int         expCycle;
  } exp_t;

  exp_t       sbQ[$];
  int         checks = 0;
  int         errors = 0;
  int         cycleCnt = 0;
  logic [7:0] lastGood = 8'h00;
  logic       prevPulse = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy),
    .bit_count (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Called on a negedge; returns on a negedge with the stop level still driven.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int stopHold,
                               input bit noise);
    exp_t e;
    e.isErr    = ~stopBit;
    e.data     = stopBit ? data : lastGood;
    e.expCycle = cycleCnt + LATENCY;
    sbQ.push_back(e);
    if (stopBit) lastGood = data;
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = data[i];
      if (noise) begin
        @(negedge clk);
        rx_in = ~data[i];
        @(negedge clk);
        rx_in = data[i];
        repeat (CPB - 2) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
    end
    rx_in = stopBit;
    repeat (stopHold) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) checkOutput("exclusive_pulse", {31'b0, frame_err}, 32'd0);
      if (data_valid || frame_err) begin
        checkOutput("single_cycle_pulse", {31'b0, prevPulse}, 32'd0);
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pulse actual valid=%0b err=%0b required none",
                   data_valid, frame_err);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("pulse_kind", {31'b0, frame_err}, {31'b0, e.isErr});
          checkOutput("data_out", {24'b0, data_out}, {24'b0, e.data});
          checkOutput("pulse_cycle", cycleCnt, e.expCycle);
        end
      end
      prevPulse = data_valid | frame_err;
    end else begin
      prevPulse = 1'b0;
    end
  end

  initial begin
    int waitCycles;
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_data_out", {24'b0, data_out}, 32'h00);
    checkOutput("reset_valid", {31'b0, data_valid}, 32'd0);
    checkOutput("reset_ferr", {31'b0, frame_err}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_bit_count", {28'b0, bit_count}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Clean 0xA5 with short mid-bit glitches away from the sample points.
    applyStimulus(8'hA5, 1'b1, CPB, 1'b1);
    repeat (10) @(negedge clk);

    // Four-cycle low glitch: START must abort without any pulse.
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("glitch_busy_high", {31'b0, busy}, 32'd1);
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("glitch_busy_low", {31'b0, busy}, 32'd0);

    // 0x3C with a low stop bit held 40 cycles: frame error, data_out keeps 0xA5.
    applyStimulus(8'h3C, 1'b0, 40, 1'b0);
    checkOutput("break_busy_high", {31'b0, busy}, 32'd1);
    checkOutput("break_data_held", {24'b0, data_out}, 32'hA5);
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("break_busy_low", {31'b0, busy}, 32'd0);
    repeat (10) @(negedge clk);

    // Back-to-back frames with no idle gap.
    applyStimulus(8'h00, 1'b1, CPB, 1'b0);
    applyStimulus(8'hFF, 1'b1, CPB, 1'b0);
    repeat (10) @(negedge clk);

    // Reset in the middle of the fifth data bit of a 0x5A frame.
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = (i == 1 || i == 3);
      repeat (CPB) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    checkOutput("mid_frame_bit_count", {28'b0, bit_count}, 32'd4);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_data_out", {24'b0, data_out}, 32'h00);
    checkOutput("midrst_valid", {31'b0, data_valid}, 32'd0);
    checkOutput("midrst_ferr", {31'b0, frame_err}, 32'd0);
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst_bit_count", {28'b0, bit_count}, 32'd0);
    rst = 1'b0;
    lastGood = 8'h00;
    repeat (10) @(negedge clk);
    applyStimulus(8'h5A, 1'b1, CPB, 1'b0);

    waitCycles = 0;
    while (sbQ.size() != 0 && waitCycles < 400) begin
      @(negedge clk);
      waitCycles++;
    end
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout actual pending=%0d required 0", sbQ.size());
    end
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
